// File: rtl/trade_pkg.sv
// Shared types and constants for the trading signal blocks.
package trade_pkg;

    typedef enum logic [1:0] {
        FLAT  = 2'd0,
        LONG  = 2'd1,
        SHORT = 2'd2
    } position_t;

    localparam int BAND_ABS  = 0;
    localparam int BAND_PROP = 1;

endpackage

// File: rtl/mean_reversion_engine_band_calc.sv
// Combinational band calculation: midpoint of the SMAs, saturated upper/lower
// band edges and the trend flag, all carried in WIDTH+1 bits.
module mean_band_calc
    import trade_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int THRESHOLD  = 5,
    parameter int BAND_SHIFT = 4,
    parameter int BAND_MODE  = BAND_ABS
) (
    input  logic [WIDTH-1:0] short_sma_i,
    input  logic [WIDTH-1:0] long_sma_i,
    output logic [WIDTH:0]   mid_o,
    output logic [WIDTH:0]   upper_o,
    output logic [WIDTH:0]   lower_o,
    output logic             trend_o
);

    localparam int W1 = WIDTH + 1;
    localparam logic [WIDTH:0] MAX_PRICE = {1'b0, {WIDTH{1'b1}}};

    logic [WIDTH:0] sum;
    logic [WIDTH:0] mid;
    logic [WIDTH:0] band;
    logic [WIDTH:0] upperRaw;
    logic [WIDTH:0] lowerRaw;

    always_comb begin
        sum      = {1'b0, short_sma_i} + {1'b0, long_sma_i};
        mid      = sum >> 1;
        band     = (BAND_MODE == BAND_PROP) ? (mid >> BAND_SHIFT) : W1'(THRESHOLD);
        upperRaw = mid + band;
        lowerRaw = mid - band;
    end

    // upperRaw cannot wrap in WIDTH+1 bits, so only the top bit needs clamping
    assign mid_o   = mid;
    assign upper_o = upperRaw[WIDTH] ? MAX_PRICE : upperRaw;
    assign lower_o = (mid > band) ? lowerRaw : '0;
    assign trend_o = short_sma_i > long_sma_i;

endmodule

// File: rtl/mean_reversion_engine.sv
// Mean-reversion signal engine: FLAT/LONG/SHORT position tracking with
// registered entry/exit pulses and a post-exit cooldown on valid samples.
module mean_reversion_engine
    import trade_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int THRESHOLD  = 5,
    parameter int BAND_SHIFT = 4,
    parameter int BAND_MODE  = 0,
    parameter int COOLDOWN   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] price,
    input  logic [WIDTH-1:0] short_sma,
    input  logic [WIDTH-1:0] long_sma,
    output logic             out_valid,
    output logic             buy_signal,
    output logic             sell_signal,
    output logic [1:0]       position,
    output logic             cooldown_active
);

    localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    logic [WIDTH:0] mid;
    logic [WIDTH:0] upper;
    logic [WIDTH:0] lower;
    logic           trend;
    logic [WIDTH:0] priceExt;

    position_t      state_q, state_d;
    logic [CD_W-1:0] cooldown_q, cooldown_d;
    logic           valid_q, valid_d;
    logic           buy_q, buy_d;
    logic           sell_q, sell_d;
    logic           cdActive_q;

    mean_band_calc #(
        .WIDTH      (WIDTH),
        .THRESHOLD  (THRESHOLD),
        .BAND_SHIFT (BAND_SHIFT),
        .BAND_MODE  (BAND_MODE)
    ) u_band (
        .short_sma_i (short_sma),
        .long_sma_i  (long_sma),
        .mid_o       (mid),
        .upper_o     (upper),
        .lower_o     (lower),
        .trend_o     (trend)
    );

    assign priceExt = {1'b0, price};

    // Exits are checked before entries, and a FLAT sample in cooldown only counts down
    always_comb begin
        state_d    = state_q;
        cooldown_d = cooldown_q;
        valid_d    = in_valid;
        buy_d      = 1'b0;
        sell_d     = 1'b0;
        if (in_valid) begin
            case (state_q)
                FLAT: begin
                    if (cooldown_q != '0) begin
                        cooldown_d = cooldown_q - 1'b1;
                    end else if (trend && (priceExt < lower)) begin
                        buy_d   = 1'b1;
                        state_d = LONG;
                    end else if (!trend && (priceExt > upper)) begin
                        sell_d  = 1'b1;
                        state_d = SHORT;
                    end
                end
                LONG: begin
                    if ((priceExt >= mid) || !trend) begin
                        sell_d     = 1'b1;
                        state_d    = FLAT;
                        cooldown_d = CD_W'(COOLDOWN);
                    end
                end
                SHORT: begin
                    if ((priceExt <= mid) || trend) begin
                        buy_d      = 1'b1;
                        state_d    = FLAT;
                        cooldown_d = CD_W'(COOLDOWN);
                    end
                end
                default: begin
                    state_d = FLAT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FLAT;
            cooldown_q <= '0;
            valid_q    <= 1'b0;
            buy_q      <= 1'b0;
            sell_q     <= 1'b0;
            cdActive_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cooldown_q <= cooldown_d;
            valid_q    <= valid_d;
            buy_q      <= buy_d;
            sell_q     <= sell_d;
            cdActive_q <= (cooldown_d != '0);
        end
    end

    assign out_valid       = valid_q;
    assign buy_signal      = buy_q;
    assign sell_signal     = sell_q;
    assign position        = state_q;
    assign cooldown_active = cdActive_q;

endmodule

// File: tb/tb_mean_reversion_engine.sv
// Directed bench for mean_reversion_engine: absolute-band instance for most
// scenarios, a second proportional-band instance for the BAND_MODE=1 case.
module tb_mean_reversion_engine;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] price;
    logic [7:0] short_sma;
    logic [7:0] long_sma;
    logic       out_valid;
    logic       buy_signal;
    logic       sell_signal;
    logic [1:0] position;
    logic       cooldown_active;

    logic       p_in_valid;
    logic [7:0] p_price;
    logic [7:0] p_short_sma;
    logic [7:0] p_long_sma;
    logic       p_out_valid;
    logic       p_buy_signal;
    logic       p_sell_signal;
    logic [1:0] p_position;
    logic       p_cooldown_active;

    int checks = 0;
    int errors = 0;
    logic [5:0] obs;

    mean_reversion_engine #(
        .WIDTH(8), .THRESHOLD(5), .BAND_SHIFT(4), .BAND_MODE(0), .COOLDOWN(2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .price           (price),
        .short_sma       (short_sma),
        .long_sma        (long_sma),
        .out_valid       (out_valid),
        .buy_signal      (buy_signal),
        .sell_signal     (sell_signal),
        .position        (position),
        .cooldown_active (cooldown_active)
    );

    mean_reversion_engine #(
        .WIDTH(8), .THRESHOLD(5), .BAND_SHIFT(4), .BAND_MODE(1), .COOLDOWN(2)
    ) dut_prop (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (p_in_valid),
        .price           (p_price),
        .short_sma       (p_short_sma),
        .long_sma        (p_long_sma),
        .out_valid       (p_out_valid),
        .buy_signal      (p_buy_signal),
        .sell_signal     (p_sell_signal),
        .position        (p_position),
        .cooldown_active (p_cooldown_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {out_valid, buy, sell, position[1:0], cooldown_active}
    function automatic logic [5:0] observed();
        return {out_valid, buy_signal, sell_signal, position, cooldown_active};
    endfunction

    function automatic logic [5:0] observedProp();
        return {p_out_valid, p_buy_signal, p_sell_signal, p_position, p_cooldown_active};
    endfunction

    task automatic applyStimulus(input logic v, input logic [7:0] p, input logic [7:0] s,
                                 input logic [7:0] l);
        in_valid  = v;
        price     = p;
        short_sma = s;
        long_sma  = l;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    task automatic applyPropStimulus(input logic v, input logic [7:0] p, input logic [7:0] s,
                                     input logic [7:0] l);
        p_in_valid  = v;
        p_price     = p;
        p_short_sma = s;
        p_long_sma  = l;
        @(posedge clk);
        #1;
        p_in_valid  = 1'b0;
    endtask

    task automatic applyReset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        p_in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        applyReset();
        obs = observed(); checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL reset_state: got %b expected %b", obs, 6'b000000);
        end
        obs = observedProp(); checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL reset_state_prop: got %b expected %b", obs, 6'b000000);
        end
    endtask

    task automatic test_long_entry();
        applyReset();
        applyStimulus(1'b1, 8'd100, 8'd110, 8'd100);
        obs = observed(); checks++;
        if (obs !== 6'b100000) begin
            errors++;
            $display("[TB] FAIL long_no_entry_at_lower: got %b expected %b", obs, 6'b100000);
        end
        applyStimulus(1'b1, 8'd99, 8'd110, 8'd100);
        obs = observed(); checks++;
        if (obs !== 6'b110010) begin
            errors++;
            $display("[TB] FAIL long_entry: got %b expected %b", obs, 6'b110010);
        end
        applyStimulus(1'b1, 8'd104, 8'd110, 8'd100);
        obs = observed(); checks++;
        if (obs !== 6'b100010) begin
            errors++;
            $display("[TB] FAIL long_hold: got %b expected %b", obs, 6'b100010);
        end
    endtask

    task automatic test_long_exit_cooldown();
        logic [5:0] expSeq [3];
        expSeq[0] = 6'b100001;
        expSeq[1] = 6'b100000;
        expSeq[2] = 6'b110010;
        applyStimulus(1'b1, 8'd105, 8'd110, 8'd100);
        obs = observed(); checks++;
        if (obs !== 6'b101001) begin
            errors++;
            $display("[TB] FAIL long_exit: got %b expected %b", obs, 6'b101001);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'd90, 8'd110, 8'd100);
            obs = observed(); checks++;
            if (obs !== expSeq[i]) begin
                errors++;
                $display("[TB] FAIL cooldown_sample%0d: got %b expected %b", i, obs, expSeq[i]);
            end
        end
    endtask

    task automatic test_short_entry_exit();
        applyReset();
        applyStimulus(1'b1, 8'd110, 8'd100, 8'd110);
        obs = observed(); checks++;
        if (obs !== 6'b100000) begin
            errors++;
            $display("[TB] FAIL short_no_entry_at_upper: got %b expected %b", obs, 6'b100000);
        end
        applyStimulus(1'b1, 8'd111, 8'd100, 8'd110);
        obs = observed(); checks++;
        if (obs !== 6'b101100) begin
            errors++;
            $display("[TB] FAIL short_entry: got %b expected %b", obs, 6'b101100);
        end
        applyStimulus(1'b1, 8'd105, 8'd100, 8'd110);
        obs = observed(); checks++;
        if (obs !== 6'b110001) begin
            errors++;
            $display("[TB] FAIL short_exit: got %b expected %b", obs, 6'b110001);
        end
    endtask

    task automatic test_saturation();
        applyReset();
        applyStimulus(1'b1, 8'd255, 8'd253, 8'd253);
        obs = observed(); checks++;
        if (obs !== 6'b100000) begin
            errors++;
            $display("[TB] FAIL upper_saturation: got %b expected %b", obs, 6'b100000);
        end
        applyStimulus(1'b1, 8'd0, 8'd3, 8'd3);
        obs = observed(); checks++;
        if (obs !== 6'b100000) begin
            errors++;
            $display("[TB] FAIL lower_floor: got %b expected %b", obs, 6'b100000);
        end
    endtask

    task automatic test_proportional_band();
        applyReset();
        applyPropStimulus(1'b1, 8'd150, 8'd170, 8'd150);
        obs = observedProp(); checks++;
        if (obs !== 6'b100000) begin
            errors++;
            $display("[TB] FAIL prop_no_entry_at_lower: got %b expected %b", obs, 6'b100000);
        end
        applyPropStimulus(1'b1, 8'd149, 8'd170, 8'd150);
        obs = observedProp(); checks++;
        if (obs !== 6'b110010) begin
            errors++;
            $display("[TB] FAIL prop_entry: got %b expected %b", obs, 6'b110010);
        end
    endtask

    task automatic test_valid_gaps();
        applyReset();
        applyStimulus(1'b1, 8'd99, 8'd110, 8'd100);
        applyStimulus(1'b1, 8'd105, 8'd110, 8'd100);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 8'd90, 8'd110, 8'd100);
            obs = observed(); checks++;
            if (obs !== 6'b000001) begin
                errors++;
                $display("[TB] FAIL gap_hold%0d: got %b expected %b", i, obs, 6'b000001);
            end
        end
        applyStimulus(1'b1, 8'd90, 8'd110, 8'd100);
        obs = observed(); checks++;
        if (obs !== 6'b100001) begin
            errors++;
            $display("[TB] FAIL gap_resume1: got %b expected %b", obs, 6'b100001);
        end
        applyStimulus(1'b1, 8'd90, 8'd110, 8'd100);
        obs = observed(); checks++;
        if (obs !== 6'b100000) begin
            errors++;
            $display("[TB] FAIL gap_resume2: got %b expected %b", obs, 6'b100000);
        end
        applyStimulus(1'b1, 8'd90, 8'd110, 8'd100);
        obs = observed(); checks++;
        if (obs !== 6'b110010) begin
            errors++;
            $display("[TB] FAIL gap_resume3: got %b expected %b", obs, 6'b110010);
        end
    endtask

    task automatic test_reset_while_long();
        applyReset();
        applyStimulus(1'b1, 8'd99, 8'd110, 8'd100);
        rst       = 1'b1;
        in_valid  = 1'b1;
        price     = 8'd105;
        short_sma = 8'd110;
        long_sma  = 8'd100;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        obs = observed(); checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("[TB] FAIL reset_while_long: got %b expected %b", obs, 6'b000000);
        end
        applyStimulus(1'b1, 8'd90, 8'd110, 8'd100);
        obs = observed(); checks++;
        if (obs !== 6'b110010) begin
            errors++;
            $display("[TB] FAIL entry_after_reset: got %b expected %b", obs, 6'b110010);
        end
    endtask

    initial begin
        rst         = 1'b0;
        in_valid    = 1'b0;
        price       = '0;
        short_sma   = '0;
        long_sma    = '0;
        p_in_valid  = 1'b0;
        p_price     = '0;
        p_short_sma = '0;
        p_long_sma  = '0;
        @(negedge clk);
        test_reset();
        test_long_entry();
        test_long_exit_cooldown();
        test_short_entry_exit();
        test_saturation();
        test_proportional_band();
        test_valid_gaps();
        test_reset_while_long();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
